alert_arbiter: RTL and testbench
================================

// Module: alert_arbiter
// PURPOSE
//   Owns the single alert LED/buzzer of the digital clock and shares it between three requesters:
//   alarm (highest priority), hourly chime (middle) and key-click beep (lowest).
//   Detects alarm and on-the-hour events from the BCD time digits and sequences the output pattern
//   on 2 Hz ticks. Handles stop and snooze for the alarm and reports which source owns the output.
// PARAMETERS
//   ALARM_TICKS  120  ring length in ticks (60 s at 2 Hz); width of the ring counter = $clog2(ALARM_TICKS+1)
//   SNOOZE_TICKS 600  snooze delay in ticks (5 min) before the alarm re-rings
//   BEEP_TICKS   1    on-time of a key beep in ticks
//   CHIME_12H    1    1: chime count = hour in 12 h form (0->12, 13->1); 0: 24 h form (0->24)
// PORTS
//   clk          in   1  system clock
//   CLR_n        in   1  reset, asynchronous, active-high
//   tick         in   1  2 Hz enable strobe, one clk wide
//   sec_one, sec_ten, min_one, min_ten, hour_one, hour_ten  in  4 each  current time, BCD
//   alm_min_one, alm_min_ten, alm_hour_one, alm_hour_ten    in  4 each  alarm time, BCD
//   alarm_en     in   1  alarm armed
//   chime_en     in   1  hourly chime enabled
//   key_beep     in   1  one-clk pulse requesting a beep
//   stop_key     in   1  one-clk pulse: end alarm, cancel snooze
//   snooze_key   in   1  one-clk pulse: end ringing, start snooze
//   led_out      out  1  alert drive
//   src          out  2  owner: 00 idle, 01 beep, 10 chime, 11 alarm
//   busy         out  1  src != 00
//   snoozing     out  1  snooze timer running
// BEHAVIOUR
//   Reset: led_out=0, src=00, busy=0, snoozing=0; all counters, pending flags and edge registers cleared,
//   immediately and also mid-sequence.
//   Triggers (sampled every clk, rising edge of the condition only, so each fires once):
//     alarm: alarm_en && hh:mm == alarm hh:mm && sec==00.  chime: chime_en && min==00 && sec==00.
//     beep: key_beep.  snooze expiry: snooze counter reaches 0.  Each trigger sets a pending flag.
//   Arbitration occurs only on tick cycles. State changes and led_out updates occur only on tick cycles.
//   States: IDLE, BEEP, CHIME, ALARM.
//   IDLE: on tick, take the highest pending flag, clear it and enter that state with led_out=1.
//   BEEP: led_out=1 for BEEP_TICKS ticks, then IDLE with led_out=0.
//   CHIME: N = bin(hour) mapped per CHIME_12H. Output is N pulses of 1 tick on + 1 tick off (2N ticks),
//   then IDLE. Chime counter is 6 bits.
//   ALARM: led_out toggles every tick for ALARM_TICKS ticks, then IDLE.
//     stop_key: IDLE on the next tick; clears the snooze timer.
//     snooze_key: IDLE on the next tick; loads the snooze counter with SNOOZE_TICKS; snoozing=1.
//   Snooze counter decrements on ticks independently of the FSM, so chime and beep may run while snoozing.
//   Expiry sets alarm pending and snoozing=0. snooze_key while already snoozing reloads the counter.
//   Preemption: a pending alarm aborts BEEP or CHIME on the next tick and starts ALARM. The aborted
//   request is discarded, not resumed. Chime aborts only a BEEP. A beep arriving while busy is dropped.
//   Simultaneous triggers (e.g. alarm set to hh:00): the highest one wins; pending lower ones are
//   cleared in the same tick.
//   stop_key or snooze_key outside ALARM: ignored, except that stop_key cancels a running snooze.
//   alarm_en falling during ALARM or while snoozing: equivalent to stop_key.
// STRUCTURE
//   alert_pkg: state encoding, SRC_* codes, bcd2bin function, 12/24 h chime-count function.
//   Sub-module alert_trigger: BCD compare plus registered rising-edge detect. Instantiated twice
//   (alarm, chime).
// TESTING
//   1. Time 02:59:59 -> 03:00:00, chime_en=1 -> src=10; 3 pulses of 1 tick on / 1 tick off; then src=00.
//   2. Time 13:00:00 with CHIME_12H=1 -> 1 pulse. Time 00:00:00 -> 12 pulses. Time 00:00:00 with
//      CHIME_12H=0 -> 24 pulses.
//   3. Alarm 07:00, time 07:00:00, both enabled -> alarm wins; 120 ticks of toggling; no chime afterwards.
//   4. Alarm ringing, snooze_key -> led 0 next tick, snoozing=1. After 600 ticks the alarm re-rings.
//      stop_key while snoozing -> snoozing=0 and no re-ring.
//   5. Chime at tick 3 of 12, then alarm trigger -> ALARM starts on the next tick; chime not resumed.
//      key_beep during CHIME -> dropped.
//   6. CLR_n asserted mid-ALARM between ticks -> led_out=0, src=00 at once; no ringing after release.

Source files
------------

// File: rtl/alert_pkg.sv
// Shared types and helpers for the clock alert arbiter: state/owner codes and
// hour conversions for the hourly chime.
package alert_pkg;

  localparam int TIME_W = 24;

  localparam logic [1:0] SRC_IDLE  = 2'b00;
  localparam logic [1:0] SRC_BEEP  = 2'b01;
  localparam logic [1:0] SRC_CHIME = 2'b10;
  localparam logic [1:0] SRC_ALARM = 2'b11;

  // State encoding doubles as the owner code driven on src.
  typedef enum logic [1:0] {
    ST_IDLE  = SRC_IDLE,
    ST_BEEP  = SRC_BEEP,
    ST_CHIME = SRC_CHIME,
    ST_ALARM = SRC_ALARM
  } state_e;

  typedef struct packed {
    logic alarm;
    logic chime;
    logic beep;
  } pend_t;

  function automatic logic [5:0] bcd2bin(input logic [3:0] ten, input logic [3:0] one);
    return 6'(ten) * 6'd10 + 6'(one);
  endfunction

  function automatic logic [5:0] chime_count(input logic [5:0] hour, input logic h12);
    if (hour == 6'd0) return h12 ? 6'd12 : 6'd24;
    if (h12 && (hour > 6'd12)) return hour - 6'd12;
    return hour;
  endfunction

endpackage

// File: rtl/alert_trigger.sv
// Masked BCD time compare with a registered rising-edge detector; fires one
// clk pulse each time the match condition becomes true.
module alert_trigger
  import alert_pkg::*;
#(
  parameter logic [TIME_W-1:0] MASK = '1
) (
  input  logic              clk,
  input  logic              CLR_n,
  input  logic              en,
  input  logic [TIME_W-1:0] now_time,
  input  logic [TIME_W-1:0] target,
  output logic              fire
);

  logic hit;
  logic hit_q, hit_d;
  logic armed_q, armed_d;

  // armed_q suppresses a spurious edge on the first clk after reset, so a
  // condition that is already true when reset releases does not fire.
  always_comb begin
    hit     = en && (((now_time ^ target) & MASK) == '0);
    hit_d   = hit;
    armed_d = 1'b1;
    fire    = hit && !hit_q && armed_q;
  end

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      hit_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hit_q   <= hit_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/alert_arbiter.sv
// Shares the clock's single alert output between alarm, hourly chime and key
// beep; sequences patterns on 2 Hz ticks and runs the alarm snooze timer.
module alert_arbiter
  import alert_pkg::*;
#(
  parameter int ALARM_TICKS  = 120,
  parameter int SNOOZE_TICKS = 600,
  parameter int BEEP_TICKS   = 1,
  parameter int CHIME_12H    = 1
) (
  input  logic       clk,
  input  logic       CLR_n,
  input  logic       tick,
  input  logic [3:0] sec_one,
  input  logic [3:0] sec_ten,
  input  logic [3:0] min_one,
  input  logic [3:0] min_ten,
  input  logic [3:0] hour_one,
  input  logic [3:0] hour_ten,
  input  logic [3:0] alm_min_one,
  input  logic [3:0] alm_min_ten,
  input  logic [3:0] alm_hour_one,
  input  logic [3:0] alm_hour_ten,
  input  logic       alarm_en,
  input  logic       chime_en,
  input  logic       key_beep,
  input  logic       stop_key,
  input  logic       snooze_key,
  output logic       led_out,
  output logic [1:0] src,
  output logic       busy,
  output logic       snoozing
);

  localparam int RING_W = $clog2(ALARM_TICKS + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_TICKS + 1);
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(ALARM_TICKS - 1);
  localparam logic [RING_W-1:0] BEEP_LOAD = RING_W'(BEEP_TICKS - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_TICKS);

  logic [TIME_W-1:0] now_time, alm_time;
  logic alarm_fire, chime_fire;

  assign now_time = {hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one};
  assign alm_time = {alm_hour_ten, alm_hour_one, alm_min_ten, alm_min_one, 8'h00};

  alert_trigger #(.MASK('1)) u_alarm_trig (
    .clk(clk), .CLR_n(CLR_n), .en(alarm_en),
    .now_time(now_time), .target(alm_time), .fire(alarm_fire)
  );

  alert_trigger #(.MASK(24'h00FFFF)) u_chime_trig (
    .clk(clk), .CLR_n(CLR_n), .en(chime_en),
    .now_time(now_time), .target('0), .fire(chime_fire)
  );

  state_e            state_q, state_d;
  logic              led_q, led_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [5:0]        chime_cnt_q, chime_cnt_d;
  pend_t             pend_q, pend_d;
  logic              exit_req_q, exit_req_d;
  logic              snoozing_q, snoozing_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic              alm_en_q, alm_en_d;

  logic  stop_evt, in_alarm, snz_load, snz_expire;
  pend_t pend_now;
  logic [5:0] chime_n;

  always_comb begin
    state_d     = state_q;
    led_d       = led_q;
    ring_cnt_d  = ring_cnt_q;
    chime_cnt_d = chime_cnt_q;
    exit_req_d  = exit_req_q;
    snoozing_d  = snoozing_q;
    snz_cnt_d   = snz_cnt_q;
    alm_en_d    = alarm_en;

    // Disarming the alarm acts exactly like pressing stop.
    stop_evt   = stop_key || (alm_en_q && !alarm_en);
    in_alarm   = (state_q == ST_ALARM);
    snz_load   = snooze_key && !stop_evt && (in_alarm || snoozing_q);
    snz_expire = tick && snoozing_q && !stop_evt && !snz_load && (snz_cnt_q == SNZ_W'(1));

    pend_now.alarm = pend_q.alarm || alarm_fire || snz_expire;
    pend_now.chime = pend_q.chime || chime_fire;
    pend_now.beep  = pend_q.beep  || key_beep;
    pend_d         = pend_now;

    chime_n = chime_count(bcd2bin(hour_ten, hour_one), CHIME_12H != 0);

    if (stop_evt) begin
      snoozing_d = 1'b0;
      snz_cnt_d  = '0;
    end else if (snz_load) begin
      snoozing_d = 1'b1;
      snz_cnt_d  = SNZ_LOAD;
    end else if (tick && snoozing_q) begin
      snz_cnt_d = snz_cnt_q - SNZ_W'(1);
      if (snz_expire) snoozing_d = 1'b0;
    end

    if (in_alarm && (stop_evt || snooze_key)) exit_req_d = 1'b1;

    // Every tick consumes all pending requests: the winner starts, the rest
    // are discarded so nothing queues up behind a busy output.
    if (tick) begin
      pend_d     = '0;
      exit_req_d = 1'b0;
      if (state_q != ST_ALARM && pend_now.alarm) begin
        state_d    = ST_ALARM;
        led_d      = 1'b1;
        ring_cnt_d = RING_LOAD;
      end else if ((state_q == ST_IDLE || state_q == ST_BEEP) && pend_now.chime) begin
        state_d     = ST_CHIME;
        led_d       = 1'b1;
        chime_cnt_d = {chime_n[4:0], 1'b0} - 6'd1;
      end else if (state_q == ST_IDLE && pend_now.beep) begin
        state_d    = ST_BEEP;
        led_d      = 1'b1;
        ring_cnt_d = BEEP_LOAD;
      end else begin
        unique case (state_q)
          ST_IDLE: led_d = 1'b0;
          ST_BEEP: begin
            if (ring_cnt_q == '0) begin
              state_d = ST_IDLE;
              led_d   = 1'b0;
            end else begin
              ring_cnt_d = ring_cnt_q - RING_W'(1);
            end
          end
          ST_CHIME: begin
            if (chime_cnt_q == '0) begin
              state_d = ST_IDLE;
              led_d   = 1'b0;
            end else begin
              chime_cnt_d = chime_cnt_q - 6'd1;
              led_d       = !led_q;
            end
          end
          ST_ALARM: begin
            if (exit_req_q || stop_evt || snooze_key || ring_cnt_q == '0) begin
              state_d = ST_IDLE;
              led_d   = 1'b0;
            end else begin
              ring_cnt_d = ring_cnt_q - RING_W'(1);
              led_d      = !led_q;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      state_q     <= ST_IDLE;
      led_q       <= 1'b0;
      ring_cnt_q  <= '0;
      chime_cnt_q <= '0;
      pend_q      <= '0;
      exit_req_q  <= 1'b0;
      snoozing_q  <= 1'b0;
      snz_cnt_q   <= '0;
      alm_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      led_q       <= led_d;
      ring_cnt_q  <= ring_cnt_d;
      chime_cnt_q <= chime_cnt_d;
      pend_q      <= pend_d;
      exit_req_q  <= exit_req_d;
      snoozing_q  <= snoozing_d;
      snz_cnt_q   <= snz_cnt_d;
      alm_en_q    <= alm_en_d;
    end
  end

  assign led_out  = led_q;
  assign src      = state_q;
  assign busy     = (state_q != ST_IDLE);
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alert_arbiter.sv
// Directed bench for alert_arbiter: a 12 h instance plus a 24 h chime instance
// driven from the same inputs.
module tb_alert_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       CLR_n, tick, alarm_en, chime_en, key_beep, stop_key, snooze_key;
  logic [3:0] sec_one, sec_ten, min_one, min_ten, hour_one, hour_ten;
  logic [3:0] alm_min_one, alm_min_ten, alm_hour_one, alm_hour_ten;
  logic       led_a, busy_a, snz_a, led_b, busy_b, snz_b;
  logic [1:0] src_a, src_b;

  alert_arbiter u_dut (
    .clk(clk), .CLR_n(CLR_n), .tick(tick),
    .sec_one(sec_one), .sec_ten(sec_ten), .min_one(min_one), .min_ten(min_ten),
    .hour_one(hour_one), .hour_ten(hour_ten),
    .alm_min_one(alm_min_one), .alm_min_ten(alm_min_ten),
    .alm_hour_one(alm_hour_one), .alm_hour_ten(alm_hour_ten),
    .alarm_en(alarm_en), .chime_en(chime_en), .key_beep(key_beep),
    .stop_key(stop_key), .snooze_key(snooze_key),
    .led_out(led_a), .src(src_a), .busy(busy_a), .snoozing(snz_a)
  );

  alert_arbiter #(.CHIME_12H(0)) u_dut24 (
    .clk(clk), .CLR_n(CLR_n), .tick(tick),
    .sec_one(sec_one), .sec_ten(sec_ten), .min_one(min_one), .min_ten(min_ten),
    .hour_one(hour_one), .hour_ten(hour_ten),
    .alm_min_one(alm_min_one), .alm_min_ten(alm_min_ten),
    .alm_hour_one(alm_hour_one), .alm_hour_ten(alm_hour_ten),
    .alarm_en(alarm_en), .chime_en(chime_en), .key_beep(key_beep),
    .stop_key(stop_key), .snooze_key(snooze_key),
    .led_out(led_b), .src(src_b), .busy(busy_b), .snoozing(snz_b)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int hour;
    int n12;
    int n24;
  } chime_vec_t;

  chime_vec_t cv[5];
  int on_a, on_b, bt_a, bt_b, ring, terr, seen;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    @(negedge clk);
    hour_ten = 4'(h / 10); hour_one = 4'(h % 10);
    min_ten  = 4'(m / 10); min_one  = 4'(m % 10);
    sec_ten  = 4'(s / 10); sec_one  = 4'(s % 10);
    @(negedge clk);
  endtask

  task automatic set_alarm(input int h, input int m);
    alm_hour_ten = 4'(h / 10); alm_hour_one = 4'(h % 10);
    alm_min_ten  = 4'(m / 10); alm_min_one  = 4'(m % 10);
  endtask

  task automatic pulse_beep();
    @(negedge clk); key_beep = 1'b1;
    @(negedge clk); key_beep = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop_key = 1'b1;
    @(negedge clk); stop_key = 1'b0;
  endtask

  task automatic pulse_snooze();
    @(negedge clk); snooze_key = 1'b1;
    @(negedge clk); snooze_key = 1'b0;
  endtask

  task automatic idle_ticks(input int n, output int busy_seen);
    busy_seen = 0;
    for (int k = 0; k < n; k++) begin
      do_tick();
      if (busy_a || busy_b) busy_seen++;
    end
  endtask

  initial begin
    cv[0] = '{3, 3, 3};
    cv[1] = '{13, 1, 13};
    cv[2] = '{0, 12, 24};
    cv[3] = '{12, 12, 12};
    cv[4] = '{23, 11, 23};

    CLR_n = 1'b1; tick = 1'b0; alarm_en = 1'b0; chime_en = 1'b0;
    key_beep = 1'b0; stop_key = 1'b0; snooze_key = 1'b0;
    {hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one} = 24'h013030;
    set_alarm(6, 30);
    repeat (3) @(negedge clk);
    check("reset_led", led_a, 0);
    check("reset_src", src_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_snoozing", snz_a, 0);
    CLR_n = 1'b0;
    repeat (2) @(negedge clk);

    // Key beep while idle: one tick on, then off.
    pulse_beep();
    do_tick();
    check("beep_src", src_a, 1);
    check("beep_led_on", led_a, 1);
    do_tick();
    check("beep_src_end", src_a, 0);
    check("beep_led_off", led_a, 0);

    // Hourly chime pulse counts for 12 h and 24 h instances.
    chime_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_time((cv[i].hour + 23) % 24, 59, 59);
      set_time(cv[i].hour, 0, 0);
      do_tick();
      check($sformatf("chime%0d_src", cv[i].hour), src_a, 2);
      on_a = led_a; on_b = led_b; bt_a = busy_a; bt_b = busy_b;
      for (int t = 0; t < 60 && (busy_a || busy_b); t++) begin
        do_tick();
        if (busy_a) begin bt_a++; on_a += led_a; end
        if (busy_b) begin bt_b++; on_b += led_b; end
      end
      check($sformatf("chime%0d_pulses12", cv[i].hour), on_a, cv[i].n12);
      check($sformatf("chime%0d_pulses24", cv[i].hour), on_b, cv[i].n24);
      check($sformatf("chime%0d_ticks12", cv[i].hour), bt_a, 2 * cv[i].n12);
      check($sformatf("chime%0d_ticks24", cv[i].hour), bt_b, 2 * cv[i].n24);
      check($sformatf("chime%0d_end_src", cv[i].hour), src_a, 0);
      check($sformatf("chime%0d_end_led", cv[i].hour), led_a, 0);
    end

    // Alarm at 07:00 collides with the 07:00 chime; alarm wins, chime discarded.
    set_alarm(7, 0);
    alarm_en = 1'b1;
    set_time(6, 59, 59);
    set_time(7, 0, 0);
    do_tick();
    check("alarm_src", src_a, 3);
    ring = busy_a; terr = (led_a != 1'b1);
    for (int k = 0; k < 130 && busy_a; k++) begin
      do_tick();
      if (busy_a) begin
        ring++;
        if (led_a != 1'(ring % 2)) terr++;
      end
    end
    check("alarm_ring_ticks", ring, 120);
    check("alarm_toggle_errors", terr, 0);
    check("alarm_end_src", src_a, 0);
    idle_ticks(6, seen);
    check("alarm_no_chime_after", seen, 0);

    // Snooze, re-ring after 600 ticks, then snooze + stop cancels.
    chime_en = 1'b0;
    set_alarm(8, 0);
    set_time(7, 59, 59);
    set_time(8, 0, 0);
    do_tick();
    check("snz_alarm_src", src_a, 3);
    do_tick();
    do_tick();
    pulse_snooze();
    do_tick();
    check("snz_led_off", led_a, 0);
    check("snz_src_idle", src_a, 0);
    check("snz_snoozing", snz_a, 1);
    idle_ticks(598, seen);
    check("snz_quiet_period", seen, 0);
    check("snz_still_snoozing", snz_a, 1);
    do_tick();
    check("snz_rering_src", src_a, 3);
    check("snz_rering_snoozing", snz_a, 0);
    pulse_snooze();
    do_tick();
    check("snz2_src_idle", src_a, 0);
    check("snz2_snoozing", snz_a, 1);
    pulse_stop();
    check("stop_clears_snooze", snz_a, 0);
    idle_ticks(620, seen);
    check("stop_no_rering", seen, 0);

    // Alarm preempts a running chime; chime and a dropped beep are not resumed.
    alarm_en = 1'b0;
    chime_en = 1'b1;
    set_time(23, 59, 59);
    set_time(0, 0, 0);
    do_tick();
    check("preempt_chime_src", src_a, 2);
    do_tick();
    do_tick();
    pulse_beep();
    set_alarm(0, 0);
    @(negedge clk); alarm_en = 1'b1;
    @(negedge clk);
    do_tick();
    check("preempt_alarm_src12", src_a, 3);
    check("preempt_alarm_src24", src_b, 3);
    check("preempt_alarm_led", led_a, 1);
    pulse_stop();
    do_tick();
    check("preempt_stop_src", src_a, 0);
    idle_ticks(6, seen);
    check("preempt_no_resume", seen, 0);
    alarm_en = 1'b0;
    chime_en = 1'b0;

    // Asynchronous clear in the middle of a ring.
    set_alarm(9, 0);
    @(negedge clk); alarm_en = 1'b1;
    set_time(8, 59, 59);
    set_time(9, 0, 0);
    do_tick();
    check("clr_alarm_src", src_a, 3);
    do_tick();
    do_tick();
    check("clr_pre_led", led_a, 1);
    @(negedge clk);
    #2 CLR_n = 1'b1;
    #1;
    check("clr_led", led_a, 0);
    check("clr_src", src_a, 0);
    check("clr_busy", busy_a, 0);
    @(negedge clk); CLR_n = 1'b0;
    idle_ticks(10, seen);
    check("clr_no_ring_after", seen, 0);

    // Disarming during a ring behaves like stop.
    set_alarm(10, 0);
    set_time(9, 59, 59);
    set_time(10, 0, 0);
    do_tick();
    check("disarm_alarm_src", src_a, 3);
    @(negedge clk); alarm_en = 1'b0;
    do_tick();
    check("disarm_src", src_a, 0);
    check("disarm_led", led_a, 0);
    check("disarm_snoozing", snz_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
